// File: rtl/gray_bin_decoder.sv
// Gray-to-binary decoder with input synchroniser, debounce filter and serial conversion.
//
// Samples an asynchronous Gray code, waits until the code has been stable for STABLE_CYCLES
// samples, then converts it MSB first at one bit per cycle. The result is offered on a
// valid/ready port, shown on an active-low 7-segment digit, and flagged when the accepted
// code moved by more than one bit since the previous accepted code.
//
// Ports:
//   clk       - system clock
//   rst_n     - asynchronous active-low reset
//   gray_in   - Gray-coded input, asynchronous to clk
//   out_ready - consumer accepts the result when out_valid && out_ready
//   out_valid - bin_out and step_err are valid
//   bin_out   - decoded binary value
//   step_err  - accepted code differs from the previous one in more than one bit
//   busy      - conversion in progress or result pending
//   seg       - active-low segments {g,f,e,d,c,b,a} showing bin_out[3:0] in hex
module gray_bin_decoder #(
  parameter int unsigned W             = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] gray_in,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] bin_out,
  output logic         step_err,
  output logic         busy,
  output logic [6:0]   seg
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned IdxW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {StIdle, StConv, StValid} state_e;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Input path: synchroniser and debounce filter.
  logic [W-1:0]    s1_q, s2_q, cand_q;
  logic [CntW-1:0] cnt_q;
  logic            stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      s1_q <= gray_in;
      s2_q <= s1_q;
      if (s2_q != cand_q) begin
        cand_q <= s2_q;
        cnt_q  <= '0;
      end else if (cnt_q != CntW'(STABLE_CYCLES)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign stable = (cnt_q == CntW'(STABLE_CYCLES));

  // Conversion state.
  state_e          state_q;
  logic [W-1:0]    code_q, bin_q, last_q, bin_out_q;
  logic [IdxW-1:0] idx_q, idx_p1;
  logic            err_q, first_q, step_err_q;
  logic [6:0]      seg_q;
  logic [W-1:0]    bin_next;

  assign idx_p1 = idx_q + 1'b1;

  // bin_next is bin_q with the current bit filled in, so the bit-0 cycle can publish the
  // complete value in the same edge that leaves CONV.
  always_comb begin
    bin_next = bin_q;
    if (idx_q == IdxW'(W - 1)) begin
      bin_next[idx_q] = code_q[idx_q];
    end else begin
      bin_next[idx_q] = bin_q[idx_p1] ^ code_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      code_q     <= '0;
      bin_q      <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      last_q     <= '0;
      first_q    <= 1'b0;
      bin_out_q  <= '0;
      step_err_q <= 1'b0;
      seg_q      <= 7'b1111111;
    end else begin
      case (state_q)
        StIdle: begin
          if (stable && ((cand_q != last_q) || !first_q)) begin
            code_q  <= cand_q;
            idx_q   <= IdxW'(W - 1);
            bin_q   <= '0;
            err_q   <= first_q && ($countones(cand_q ^ last_q) > 1);
            state_q <= StConv;
          end
        end
        StConv: begin
          bin_q <= bin_next;
          if (idx_q == '0) begin
            bin_out_q  <= bin_next;
            step_err_q <= err_q;
            seg_q      <= hex7(4'(bin_next));
            state_q    <= StValid;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        StValid: begin
          if (out_ready) begin
            last_q  <= code_q;
            first_q <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid = (state_q == StValid);
  assign busy      = (state_q != StIdle);
  assign bin_out   = bin_out_q;
  assign step_err  = step_err_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_gray_bin_decoder.sv
module tb_gray_bin_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] gray_in;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] bin_out;
  logic       step_err;
  logic       busy;
  logic [6:0] seg;

  int checks   = 0;
  int failures = 0;

  // Reference model state: last accepted code and whether any code has been accepted.
  logic [3:0] m_last;
  bit         m_first;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  always #5 clk = ~clk;

  gray_bin_decoder #(
    .W             (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gray_in   (gray_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .bin_out   (bin_out),
    .step_err  (step_err),
    .busy      (busy),
    .seg       (seg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Binary value is the XOR of all right-shifts of the Gray code.
  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b = g;
    for (int s = 1; s < 4; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic int pop(input logic [3:0] x);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) n += int'((x >> i) & 4'd1);
    return n;
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    m_first = 1'b0;
    m_last  = 4'd0;
  endtask

  // Drive a code for 'hold' cycles with out_ready=1 and check exactly the predicted outputs.
  task automatic apply_code(input logic [3:0] code, input int hold, input string tag);
    bit         exp_emit;
    logic [3:0] eb;
    bit         ee;
    int         nv;
    exp_emit = !m_first || (code != m_last);
    eb       = g2b(code);
    ee       = m_first && (pop(code ^ m_last) > 1);
    gray_in  = code;
    nv       = 0;
    for (int i = 0; i < hold; i++) begin
      cycle();
      if (out_valid) begin
        nv++;
        check({tag, ".bin"}, 32'(bin_out), 32'(eb));
        check({tag, ".err"}, 32'(step_err), 32'(ee));
        check({tag, ".seg"}, 32'(seg), 32'(SEG_TBL[eb]));
      end
    end
    check({tag, ".nvalid"}, nv, exp_emit ? 1 : 0);
    if (exp_emit) begin
      m_last  = code;
      m_first = 1'b1;
    end
  endtask

  initial begin
    int n;
    int bad;
    bit seen;
    logic [3:0] g;

    rst_n     = 1'b0;
    gray_in   = 4'b1111;
    out_ready = 1'b1;
    m_first   = 1'b0;
    m_last    = 4'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst.valid", 32'(out_valid), 0);
    check("rst.bin", 32'(bin_out), 0);
    check("rst.seg", 32'(seg), 32'h7f);
    check("rst.busy", 32'(busy), 0);
    check("rst.err", 32'(step_err), 0);

    // First-result latency: valid appears after edge 11 counted from the first s1 sample.
    rst_n   = 1'b1;
    gray_in = 4'b0110;
    for (int e = 0; e <= 11; e++) begin
      cycle();
      if (e == 6) check("lat.busy6", 32'(busy), 0);
      if (e == 8) check("lat.busy8", 32'(busy), 1);
      if (e == 10) check("lat.valid10", 32'(out_valid), 0);
      if (e == 11) begin
        check("lat.valid11", 32'(out_valid), 1);
        check("lat.bin", 32'(bin_out), 32'h4);
        check("lat.seg", 32'(seg), 32'(7'b0011001));
        check("lat.err", 32'(step_err), 0);
      end
    end
    cycle();
    check("lat.accepted", 32'(out_valid), 0);

    // Full Gray walk including the wrap-around step.
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      n = k % 16;
      g = 4'(n ^ (n >> 1));
      apply_code(g, 20, "walk");
    end

    // Short glitch away from an accepted code.
    gray_in = 4'b0001;
    repeat (2) cycle();
    apply_code(4'b0000, 30, "glitch");

    // Two-bit jump.
    apply_code(4'b0101, 20, "skip");

    // Backpressure: result held while a newer code arrives.
    out_ready = 1'b0;
    gray_in   = 4'b0011;
    seen      = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cycle();
      if (out_valid) seen = 1'b1;
    end
    check("bp.seen", 32'(seen), 1);
    check("bp.bin", 32'(bin_out), 32'h2);
    check("bp.err", 32'(step_err), 32'(pop(4'b0011 ^ m_last) > 1));
    m_last  = 4'b0011;
    gray_in = 4'b0111;
    bad     = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (!out_valid || bin_out != 4'b0010) bad++;
    end
    check("bp.hold", bad, 0);
    out_ready = 1'b1;
    cycle();
    check("bp.released", 32'(out_valid), 0);
    apply_code(4'b0111, 20, "after_bp");

    // Reset in the middle of a conversion.
    gray_in = 4'b1111;
    seen    = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      if (busy) seen = 1'b1;
    end
    check("midrst.busy_seen", 32'(seen), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.valid", 32'(out_valid), 0);
    check("midrst.seg", 32'(seg), 32'h7f);
    check("midrst.busy", 32'(busy), 0);
    check("midrst.bin", 32'(bin_out), 0);
    @(negedge clk);
    rst_n   = 1'b1;
    m_first = 1'b0;
    m_last  = 4'd0;

    // Random held codes; repeats of the last accepted code must not be re-emitted.
    for (int k = 0; k < 30; k++) begin
      g = 4'($urandom_range(0, 15));
      apply_code(g, int'($urandom_range(14, 25)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
